// File: rtl/compl_mul_sched_if.sv
// Operand/result bundle between the channel front-ends, the scheduler
// and the shared complex multiplier.
//
// Signals (names as seen from the scheduler):
//   req_valid_i / req_ready_o : per-requester handshake
//   req_{a,b}_{i,q}_i         : packed operands, slice k = requester k
//   mul_{a,b}_{i,q}_o         : registered operands to the multiplier
//   mul_{i,q}_i               : rounded multiplier outputs
//   res_valid_o/res_id_o      : tagged result strobe
//   res_{i,q}_o               : result data
// Modports: slave = scheduler, master = front-ends/multiplier/consumer.
interface compl_mul_sched_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 18,
    parameter int IDW   = $clog2(N_REQ)
) ();
    logic [N_REQ-1:0]    req_valid_i;
    logic [N_REQ-1:0]    req_ready_o;
    logic [N_REQ*DW-1:0] req_a_i_i;
    logic [N_REQ*DW-1:0] req_a_q_i;
    logic [N_REQ*DW-1:0] req_b_i_i;
    logic [N_REQ*DW-1:0] req_b_q_i;
    logic signed [DW-1:0] mul_a_i_o;
    logic signed [DW-1:0] mul_a_q_o;
    logic signed [DW-1:0] mul_b_i_o;
    logic signed [DW-1:0] mul_b_q_o;
    logic signed [DW:0]   mul_i_i;
    logic signed [DW:0]   mul_q_i;
    logic                 res_valid_o;
    logic [IDW-1:0]       res_id_o;
    logic signed [DW:0]   res_i_o;
    logic signed [DW:0]   res_q_o;

    modport slave (
        input  req_valid_i, req_a_i_i, req_a_q_i,
        input  req_b_i_i, req_b_q_i,
        input  mul_i_i, mul_q_i,
        output req_ready_o,
        output mul_a_i_o, mul_a_q_o, mul_b_i_o, mul_b_q_o,
        output res_valid_o, res_id_o, res_i_o, res_q_o
    );

    modport master (
        output req_valid_i, req_a_i_i, req_a_q_i,
        output req_b_i_i, req_b_q_i,
        output mul_i_i, mul_q_i,
        input  req_ready_o,
        input  mul_a_i_o, mul_a_q_o, mul_b_i_o, mul_b_q_o,
        input  res_valid_o, res_id_o, res_i_o, res_q_o
    );
endinterface

// File: rtl/compl_mul_sched.sv
// Round-robin scheduler sharing one pipelined complex multiplier among
// N_REQ requesters, returning each product tagged with its requester ID.
//
// Ports:
//   clk_i      : clock, rising edge
//   srst_i     : synchronous active-high reset
//   en_i       : grant enable (0 stalls new grants, results still drain)
//   bus        : operand handshakes, multiplier link, tagged results
//   inflight_o : accepted products not yet returned
//   busy_o     : inflight_o nonzero
module compl_mul_sched #(
    parameter int N_REQ   = 4,
    parameter int DW      = 18,
    parameter int MUL_LAT = 2,
    parameter int IDW     = $clog2(N_REQ),
    localparam int CW     = $clog2(MUL_LAT + 2)
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic                en_i,
    compl_mul_sched_if.slave    bus,
    output logic [CW-1:0]       inflight_o,
    output logic                busy_o
);

    logic [IDW-1:0]       r_ptr;
    logic signed [DW-1:0] r_a_i;
    logic signed [DW-1:0] r_a_q;
    logic signed [DW-1:0] r_b_i;
    logic signed [DW-1:0] r_b_q;
    logic [MUL_LAT:0]     r_tag_v;
    logic [IDW-1:0]       r_tag_id [MUL_LAT+1];
    logic [CW-1:0]        r_inflight;

    logic                 w_found;
    logic [IDW-1:0]       w_win;
    logic [IDW-1:0]       w_idx;
    logic                 w_accept;
    logic                 w_res_valid;

    // Scan from the pointer, wrapping modulo N_REQ; first valid wins.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(r_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            w_idx = IDW'(j);
            if (!w_found && bus.req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_accept    = w_found & en_i & ~srst_i;
    assign w_res_valid = r_tag_v[MUL_LAT];

    assign bus.req_ready_o = w_accept ? (N_REQ'(1) << w_win) : '0;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_ptr      <= '0;
            r_a_i      <= '0;
            r_a_q      <= '0;
            r_b_i      <= '0;
            r_b_q      <= '0;
            r_tag_v    <= '0;
            r_inflight <= '0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_a_i <= bus.req_a_i_i[w_win*DW +: DW];
                r_a_q <= bus.req_a_q_i[w_win*DW +: DW];
                r_b_i <= bus.req_b_i_i[w_win*DW +: DW];
                r_b_q <= bus.req_b_q_i[w_win*DW +: DW];
                r_ptr <= (w_win == IDW'(N_REQ - 1)) ?
                         '0 : w_win + 1'b1;
            end
            // Stage 0 mirrors the operand register; the remaining
            // MUL_LAT stages track the multiplier pipeline.
            r_tag_v     <= {r_tag_v[MUL_LAT-1:0], w_accept};
            r_tag_id[0] <= w_accept ? w_win : '0;
            for (int k = 1; k <= MUL_LAT; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
            case ({w_accept, w_res_valid})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.mul_a_i_o   = r_a_i;
    assign bus.mul_a_q_o   = r_a_q;
    assign bus.mul_b_i_o   = r_b_i;
    assign bus.mul_b_q_o   = r_b_q;
    assign bus.res_valid_o = w_res_valid;
    assign bus.res_id_o    = r_tag_id[MUL_LAT];
    assign bus.res_i_o     = bus.mul_i_i;
    assign bus.res_q_o     = bus.mul_q_i;
    assign inflight_o      = r_inflight;
    assign busy_o          = |r_inflight;

endmodule

// File: tb/tb_compl_mul_sched.sv
// Self-checking bench for compl_mul_sched with a behavioural
// multiplier and a queue-based reference model.
module tb_compl_mul_sched;
    localparam int N   = 4;
    localparam int DW  = 18;
    localparam int ML  = 2;
    localparam int IDW = 2;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          srst;
    logic          en;
    logic [CW-1:0] inflight;
    logic          busy;

    compl_mul_sched_if #(.N_REQ(N), .DW(DW), .IDW(IDW)) bus ();

    compl_mul_sched #(.N_REQ(N), .DW(DW), .MUL_LAT(ML), .IDW(IDW)) dut (
        .clk_i      (clk),
        .srst_i     (srst),
        .en_i       (en),
        .bus        (bus),
        .inflight_o (inflight),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] op [N][4];
    logic [N-1:0]  vld;

    always_comb begin
        bus.req_a_i_i   = '0;
        bus.req_a_q_i   = '0;
        bus.req_b_i_i   = '0;
        bus.req_b_q_i   = '0;
        bus.req_valid_i = vld;
        for (int k = 0; k < N; k++) begin
            bus.req_a_i_i[k*DW +: DW] = op[k][0];
            bus.req_a_q_i[k*DW +: DW] = op[k][1];
            bus.req_b_i_i[k*DW +: DW] = op[k][2];
            bus.req_b_q_i[k*DW +: DW] = op[k][3];
        end
    end

    function automatic logic signed [DW:0] rnd(longint p);
        longint r;
        r = (p + 64'sd32768) >>> 16;
        return r[DW:0];
    endfunction

    function automatic logic signed [DW:0] cm_i(
        logic signed [DW-1:0] ai, logic signed [DW-1:0] aq,
        logic signed [DW-1:0] bi, logic signed [DW-1:0] bq);
        return rnd(longint'(ai) * longint'(bi) - longint'(aq) * longint'(bq));
    endfunction

    function automatic logic signed [DW:0] cm_q(
        logic signed [DW-1:0] ai, logic signed [DW-1:0] aq,
        logic signed [DW-1:0] bi, logic signed [DW-1:0] bq);
        return rnd(longint'(ai) * longint'(bq) + longint'(aq) * longint'(bi));
    endfunction

    // Behavioural multiplier: ML register stages after the operand regs.
    logic signed [DW:0] pi [ML];
    logic signed [DW:0] pq [ML];

    always @(posedge clk) begin
        if (srst) begin
            for (int k = 0; k < ML; k++) begin
                pi[k] <= '0;
                pq[k] <= '0;
            end
        end else begin
            pi[0] <= cm_i(bus.mul_a_i_o, bus.mul_a_q_o, bus.mul_b_i_o, bus.mul_b_q_o);
            pq[0] <= cm_q(bus.mul_a_i_o, bus.mul_a_q_o, bus.mul_b_i_o, bus.mul_b_q_o);
            for (int k = 1; k < ML; k++) begin
                pi[k] <= pi[k-1];
                pq[k] <= pq[k-1];
            end
        end
    end

    assign bus.mul_i_i = pi[ML-1];
    assign bus.mul_q_i = pq[ML-1];

    // Reference model state.
    typedef struct {
        int                 id;
        int                 due;
        logic signed [DW:0] ri;
        logic signed [DW:0] rq;
    } exp_t;

    exp_t               mq [$];
    int                 m_ptr;
    int                 m_edge;
    int                 m_inflight;
    logic signed [DW-1:0] m_op [4];
    int                 g_win;
    int                 checks = 0;
    int                 errors = 0;
    int                 nres;

    typedef struct {
        logic [N-1:0] v;
        logic         e;
        logic [N-1:0] rdy;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(string nm, logic signed [63:0] got, logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic new_ops(int k);
        for (int j = 0; j < 4; j++) begin
            op[k][j] = DW'($urandom);
        end
    endtask

    // Check all outputs against the model, then advance one edge.
    task automatic step();
        int           win;
        bit           rv;
        logic [N-1:0] er;
        #1;
        win = -1;
        if (en && !srst) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (win < 0 && vld[k]) win = k;
            end
        end
        er = '0;
        if (win >= 0) er[win] = 1'b1;
        chk("ready", bus.req_ready_o, er);
        rv = (mq.size() > 0) && (mq[0].due == m_edge);
        chk("res_valid", bus.res_valid_o, rv);
        if (rv) begin
            chk("res_id", bus.res_id_o, mq[0].id);
            chk("res_i", bus.res_i_o, mq[0].ri);
            chk("res_q", bus.res_q_o, mq[0].rq);
        end
        chk("inflight", inflight, m_inflight);
        chk("busy", busy, m_inflight != 0);
        chk("mul_a", {bus.mul_a_i_o, bus.mul_a_q_o}, {m_op[0], m_op[1]});
        chk("mul_b", {bus.mul_b_i_o, bus.mul_b_q_o}, {m_op[2], m_op[3]});
        if (srst) begin
            mq.delete();
            m_ptr      = 0;
            m_inflight = 0;
            for (int j = 0; j < 4; j++) m_op[j] = '0;
        end else begin
            if (rv) void'(mq.pop_front());
            m_inflight = m_inflight + (win >= 0 ? 1 : 0) - (rv ? 1 : 0);
            if (win >= 0) begin
                for (int j = 0; j < 4; j++) m_op[j] = op[win][j];
                m_ptr = (win + 1) % N;
                mq.push_back('{id: win, due: m_edge + ML + 1,
                               ri: cm_i(m_op[0], m_op[1], m_op[2], m_op[3]),
                               rq: cm_q(m_op[0], m_op[1], m_op[2], m_op[3])});
            end
        end
        g_win = win;
        m_edge++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        vld  = '0;
        step();
        srst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'b0001, 1'b1, 4'b0001};
        tbl[1] = '{4'b1111, 1'b1, 4'b0010};
        tbl[2] = '{4'b1010, 1'b1, 4'b1000};
        tbl[3] = '{4'b1010, 1'b1, 4'b0010};
        tbl[4] = '{4'b1010, 1'b1, 4'b1000};
        tbl[5] = '{4'b1111, 1'b0, 4'b0000};
        tbl[6] = '{4'b1111, 1'b1, 4'b0001};
        tbl[7] = '{4'b0100, 1'b1, 4'b0100};
        tbl[8] = '{4'b0000, 1'b1, 4'b0000};
        tbl[9] = '{4'b0011, 1'b1, 4'b0001};

        srst = 1'b1;
        en   = 1'b0;
        vld  = '0;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 4; j++) op[k][j] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_ptr      = 0;
        m_edge     = 0;
        m_inflight = 0;
        g_win      = -1;
        for (int j = 0; j < 4; j++) m_op[j] = '0;
        step();
        srst = 1'b0;

        // Single requester, unit-magnitude operands.
        en = 1'b1;
        op[0][0] = 18'h10000;
        op[0][1] = 18'h10000;
        op[0][2] = 18'h10000;
        op[0][3] = 18'h10000;
        vld = 4'b0001;
        #1 chk("t1_rdy", bus.req_ready_o, 4'b0001);
        step();
        vld = '0;
        step();
        step();
        #1;
        chk("t1_valid", bus.res_valid_o, 1);
        chk("t1_id", bus.res_id_o, 0);
        chk("t1_i", bus.res_i_o, 0);
        chk("t1_q", bus.res_q_o, 19'sh20000);
        step();
        #1 chk("t1_inflight", inflight, 0);

        // Arbitration table.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            vld = tbl[i].v;
            en  = tbl[i].e;
            for (int k = 0; k < N; k++) new_ops(k);
            #1 chk($sformatf("tbl%0d_rdy", i), bus.req_ready_o, tbl[i].rdy);
            step();
        end
        vld = '0;
        en  = 1'b1;
        repeat (4) step();

        // All four requesters valid for 8 cycles.
        do_reset();
        for (int k = 0; k < N; k++) new_ops(k);
        vld = '1;
        for (int i = 0; i < 8; i++) begin
            #1 chk("burst_gnt", bus.req_ready_o, 4'b0001 << (i % 4));
            if (i >= 3) chk("burst_infl", inflight, 3);
            step();
            new_ops(g_win);
        end
        vld = '0;
        repeat (4) step();

        // Enable drop mid-burst.
        do_reset();
        vld = '1;
        repeat (3) begin
            step();
            new_ops(g_win);
        end
        en   = 1'b0;
        nres = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("en_rdy", bus.req_ready_o, 0);
            if (bus.res_valid_o === 1'b1) nres++;
            step();
        end
        chk("en_drain", nres, 3);
        en = 1'b1;
        #1 chk("en_resume", bus.req_ready_o, 4'b1000);
        step();
        vld = '0;
        repeat (4) step();

        // Reset with three products in flight.
        do_reset();
        vld = '1;
        repeat (3) step();
        srst = 1'b1;
        step();
        srst = 1'b0;
        vld  = '0;
        #1;
        chk("rst_infl", inflight, 0);
        chk("rst_mul", {bus.mul_a_i_o, bus.mul_b_q_o}, 0);
        nres = 0;
        for (int i = 0; i < 4; i++) begin
            #1 if (bus.res_valid_o !== 1'b0) nres++;
            step();
        end
        chk("rst_nores", nres, 0);
        vld = '1;
        #1 chk("rst_gnt", bus.req_ready_o, 4'b0001);
        step();
        vld = '0;
        repeat (4) step();

        // Rounding of a half-LSB product from requester 2.
        do_reset();
        op[2][0] = 18'h08000;
        op[2][1] = 18'h00000;
        op[2][2] = 18'h00001;
        op[2][3] = 18'h00000;
        vld = 4'b0100;
        #1 chk("rnd_rdy", bus.req_ready_o, 4'b0100);
        step();
        vld = '0;
        step();
        step();
        #1;
        chk("rnd_valid", bus.res_valid_o, 1);
        chk("rnd_id", bus.res_id_o, 2);
        chk("rnd_i", bus.res_i_o, 1);
        chk("rnd_q", bus.res_q_o, 0);
        step();

        // Randomized traffic with hold-until-accepted requesters.
        for (int c = 0; c < 400; c++) begin
            srst = ($urandom_range(0, 39) == 0);
            en   = ($urandom_range(0, 5) != 0);
            for (int k = 0; k < N; k++) begin
                if (!vld[k] && $urandom_range(0, 1) == 1) begin
                    new_ops(k);
                    vld[k] = 1'b1;
                end
            end
            step();
            if (g_win >= 0) vld[g_win] = 1'b0;
        end
        srst = 1'b0;
        vld  = '0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
